// File: rtl/matmul_skew_feeder.sv
// Snapshots operands A (NxK) and B (KxM) on a start edge and streams them as diagonally skewed
// edge vectors into a systolic array. Optional macro: MATMUL_SKEW_FEEDER_TRANSPOSE_B_EN.
module matmul_skew_feeder #(
  parameter int unsigned DW      = 8,
  parameter int unsigned MAX_DIM = 4,
  parameter int unsigned DIM_W   = $clog2(MAX_DIM),
  parameter int unsigned PE_LAT  = 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic [DIM_W-1:0]            n_dim_i,
  input  logic [DIM_W-1:0]            k_dim_i,
  input  logic [DIM_W-1:0]            m_dim_i,
  input  logic [MAX_DIM*MAX_DIM*DW-1:0] mat_a_i,
  input  logic [MAX_DIM*MAX_DIM*DW-1:0] mat_b_i,
`ifdef MATMUL_SKEW_FEEDER_TRANSPOSE_B_EN
  input  logic                        b_trans_i,
`endif
  output logic [MAX_DIM*DW-1:0]       vec_a_o,
  output logic [MAX_DIM*DW-1:0]       vec_b_o,
  output logic                        vec_valid_o,
  output logic                        clear_acc_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int unsigned CW  = $clog2(3 * MAX_DIM);
  localparam int unsigned DRW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
  localparam int unsigned MW  = MAX_DIM * MAX_DIM * DW;
  localparam int unsigned VW  = MAX_DIM * DW;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StClear = 3'd1;
  localparam logic [2:0] StFeed  = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    t_q, t_d;
  logic [DRW-1:0]   drain_q, drain_d;
  logic             start_prev_q, start_prev_d;
  logic [DIM_W-1:0] n_q, n_d, k_q, k_d, m_q, m_d;
  logic [MW-1:0]    mat_a_q, mat_a_d, mat_b_q, mat_b_d;
  logic [VW-1:0]    vec_a_q, vec_a_d, vec_b_q, vec_b_d;
  logic             b_trans_q, b_trans_d;
  logic             accept;
  logic [CW-1:0]    t_last;

  // Out-of-range dimension codes only exist when MAX_DIM is not a power of two.
  function automatic logic [DIM_W-1:0] sat_dim(input logic [DIM_W-1:0] v);
    if (int'(v) > int'(MAX_DIM) - 1) return DIM_W'(MAX_DIM - 1);
    return v;
  endfunction

  assign accept = (state_q == StIdle) && start_i && !start_prev_q;
  // Last feed index T-1 = (N-1)+(K-1)+(M-1), which is exactly the sum of the stored codes.
  assign t_last = CW'(n_q) + CW'(k_q) + CW'(m_q);

  always_comb begin
    state_d      = state_q;
    t_d          = t_q;
    drain_d      = drain_q;
    start_prev_d = start_i;
    n_d          = n_q;
    k_d          = k_q;
    m_d          = m_q;
    mat_a_d      = mat_a_q;
    mat_b_d      = mat_b_q;
    b_trans_d    = b_trans_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StClear;
          n_d     = sat_dim(n_dim_i);
          k_d     = sat_dim(k_dim_i);
          m_d     = sat_dim(m_dim_i);
          mat_a_d = mat_a_i;
          mat_b_d = mat_b_i;
`ifdef MATMUL_SKEW_FEEDER_TRANSPOSE_B_EN
          b_trans_d = b_trans_i;
`else
          b_trans_d = 1'b0;
`endif
        end
      end
      StClear: begin
        state_d = StFeed;
        t_d     = '0;
      end
      StFeed: begin
        if (t_q == t_last) begin
          state_d = StDrain;
          drain_d = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == DRW'(PE_LAT - 1)) state_d = StDone;
        else drain_d = drain_q + 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_i && state_q != StIdle) state_d = StIdle;
  end

  // Vectors are computed from the next state so the output registers line up with FEED.
  always_comb begin
    int d;
    d       = 0;
    vec_a_d = '0;
    vec_b_d = '0;
    if (state_d == StFeed) begin
      for (int i = 0; i < int'(MAX_DIM); i++) begin
        d = int'(t_d) - i;
        if (d >= 0 && d <= int'(k_q)) begin
          if (i <= int'(n_q)) vec_a_d[i*DW +: DW] = mat_a_q[(i*int'(MAX_DIM) + d)*DW +: DW];
          if (i <= int'(m_q)) begin
            if (b_trans_q) vec_b_d[i*DW +: DW] = mat_b_q[(i*int'(MAX_DIM) + d)*DW +: DW];
            else           vec_b_d[i*DW +: DW] = mat_b_q[(d*int'(MAX_DIM) + i)*DW +: DW];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      t_q          <= '0;
      drain_q      <= '0;
      start_prev_q <= 1'b0;
      n_q          <= '0;
      k_q          <= '0;
      m_q          <= '0;
      mat_a_q      <= '0;
      mat_b_q      <= '0;
      b_trans_q    <= 1'b0;
      vec_a_q      <= '0;
      vec_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      drain_q      <= drain_d;
      start_prev_q <= start_prev_d;
      n_q          <= n_d;
      k_q          <= k_d;
      m_q          <= m_d;
      mat_a_q      <= mat_a_d;
      mat_b_q      <= mat_b_d;
      b_trans_q    <= b_trans_d;
      vec_a_q      <= vec_a_d;
      vec_b_q      <= vec_b_d;
    end
  end

  assign vec_a_o     = vec_a_q;
  assign vec_b_o     = vec_b_q;
  assign vec_valid_o = (state_q == StFeed);
  assign clear_acc_o = (state_q == StClear);
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);

endmodule

// File: doc/matmul_skew_feeder.md
Name: matmul_skew_feeder

Overview:
- Parametrised successor to the fixed 4x4 padding/feed stage of the matmul accelerator.
- Snapshots operand matrices A (N x K) and B (K x M) on start and streams them as diagonally skewed edge vectors into the systolic matmul_calc array.
- Row i of A enters the array delayed i cycles; column j of B enters delayed j cycles.
- Sequences clear, feed, drain and done for any N, K, M up to MAX_DIM, independent of bus width, with abort support.

Parameters:
- DW, 8, bits per matrix element.
- MAX_DIM, 4, array dimension; any value >= 2.
- DIM_W, $clog2(MAX_DIM), width of the dimension fields.
- PE_LAT, 1, cycles from the last edge vector until the far-corner PE result is final; >= 1.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  level; rising edge requests an operation.
- abort_i  in  1  synchronous abort of the running operation.
- n_dim_i  in  DIM_W  rows of A minus 1.
- k_dim_i  in  DIM_W  cols of A / rows of B minus 1.
- m_dim_i  in  DIM_W  cols of B minus 1.
- mat_a_i  in  MAX_DIM*MAX_DIM*DW  A row-major; element [r][c] at bits ((r*MAX_DIM+c)*DW)+:DW.
- mat_b_i  in  MAX_DIM*MAX_DIM*DW  B row-major, same packing.
- vec_a_o  out  MAX_DIM*DW  slot i = element entering array row i.
- vec_b_o  out  MAX_DIM*DW  slot j = element entering array column j.
- vec_valid_o  out  1  high in every FEED cycle.
- clear_acc_o  out  1  one-cycle pulse; array clears its accumulators.
- busy_o  out  1  high from the cycle after start is accepted until done_o.
- done_o  out  1  one-cycle pulse when results are final.

Behaviour:
- Reset: all outputs 0; FSM IDLE; snapshot registers 0; start edge detector history 0.
- Reset asserted mid-operation: immediate return to IDLE; no done_o; vectors go 0 asynchronously.
- Start acceptance: start_i=1 with previous sample 0, in IDLE only.
  - A start edge outside IDLE is ignored and not queued.
  - On acceptance, latch N=n_dim_i+1, K=k_dim_i+1, M=m_dim_i+1, mat_a_i and mat_b_i.
  - Inputs may change afterwards without effect.
- Dimension values above MAX_DIM-1 cannot occur when MAX_DIM is a power of 2. Otherwise they saturate to MAX_DIM-1.
- FSM states:
  - IDLE: on accept -> CLEAR.
  - CLEAR: 1 cycle; clear_acc_o=1; busy_o=1; -> FEED.
  - FEED: cycle counter t = 0 .. T-1, T = K+N+M-2; vec_valid_o=1.
    - vec_a slot i = A[i][t-i] if i<N and 0<=t-i<K, else 0.
    - vec_b slot j = B[t-j][j] if j<M and 0<=t-j<K, else 0.
    - At t=T-1 -> DRAIN.
  - DRAIN: PE_LAT cycles; vectors 0; vec_valid_o=0 -> DONE.
  - DONE: 1 cycle; done_o=1; busy_o=1 -> IDLE.
  - busy_o drops in the cycle after DONE.
- Latency: start edge sampled at cycle c gives
  - clear_acc_o at c+1,
  - first FEED at c+2,
  - done_o at c+2+T+PE_LAT.
- Vectors are registered outputs and are 0 outside FEED.
- Slot index order: slot 0 occupies the LSBs.
- Abort: abort_i=1 in any non-IDLE state -> IDLE next cycle.
  - No done_o; vectors 0; busy_o 0 next cycle.
  - Abort has priority over all state transitions.
- Abort and start together in IDLE: abort ignored, start accepted.
- Minimum case N=K=M=1: T=1; single FEED cycle with A[0][0], B[0][0].
- Counter width: $clog2(3*MAX_DIM) bits; no wrap possible.

Optional Feature:
- Macro: MATMUL_SKEW_FEEDER_TRANSPOSE_B_EN.
- When defined:
  - adds input port b_trans_i (1 bit), latched at start.
  - If the latched b_trans_i=1, mat_b_i holds B transposed (element [j][k] = B[k][j]), and the feeder reads mat_b at [j][t-j].
  - If the latched b_trans_i=0, behaviour is identical to the macro undefined.
- When undefined: port absent; B is always row-major.

Test Plan:
- Single operation, MAX_DIM=4, DW=8, N=K=M=4, A[r][c]=r*4+c+1, B=identity, start at cycle 0:
  - clear_acc_o at cycle 1.
  - FEED cycles 2-11, T=10.
  - At t=3, vec_a slots = {A[0][3],A[1][2],A[2][1],A[3][0]} = {4,7,10,13}.
  - done_o at cycle 13 (PE_LAT=1).
- Reduced dimensions, N=2 K=3 M=1:
  - T=4.
  - vec_a slots 2-3 and vec_b slots 1-3 are 0 in every cycle.
  - done_o 7 cycles after the accepted start edge.
- Snapshot and ignore:
  - Change mat_a_i to all 0xFF during FEED -> output still carries the latched values.
  - Second start edge while busy -> no second clear_acc_o and no second done_o.
- Abort:
  - abort_i=1 at FEED t=2 -> IDLE next cycle; busy_o=0; no done_o; vectors 0.
  - New start 2 cycles later -> full normal sequence.
- Async reset: assert reset_i mid-DRAIN, between clock edges -> all outputs 0 before the next edge; no done_o.
- Transpose (macro defined), b_trans_i=1 with mat_b_i = B transposed, operands as in the first scenario -> vec_b stream identical to the first scenario cycle-by-cycle.
